// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// requester IDs and the reset level used by the core.
package mem_bus_arbiter_pkg;

  // Core-wide reset level (active-low)
  localparam logic RST_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_REQ_IF  = 3'd1,
    ARB_WAIT_IF = 3'd2,
    ARB_REQ_LS  = 3'd3,
    ARB_WAIT_LS = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Memory-side request/response bus between the arbiter (master) and the
// external memory / AXI bridge (slave).
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = DATA_W / 8
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/mem_bus_arbiter_req_latch.sv
// Request register slice: captures the granted request fields and holds
// them stable on the memory bus until the next grant.
module arb_req_latch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              wen_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [MASK_W-1:0] wmask_in,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [MASK_W-1:0] wmask
);

  // Capture on grant, hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      wmask <= '0;
    end else if (load) begin
      wen   <= wen_in;
      addr  <= addr_in;
      wdata <= wdata_in;
      wmask <= wmask_in;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single core memory port between instruction fetch (IF)
// and load/store (LS), one outstanding transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention
// instead of fixed LS priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_wen,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [MASK_W-1:0] ls_req_wmask,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  input  logic              flush,
  mem_bus_arbiter_if.master mem,
  output logic              if_stall_req,
  output logic              ls_stall_req
);

  arb_state_t        state, state_nxt;
  logic              drop;
  logic              run;
  logic              if_elig;
  logic              pick_ls;
  logic              pick_if;
  logic              ld_wen;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [MASK_W-1:0] ld_wmask;

  // Outputs are forced low while reset is held, even with inputs active
  assign run     = (rst != RST_LEVEL);
  assign if_elig = if_req_valid & ~flush;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;

  // Remember which requester won most recently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              last_grant <= GRANT_IF;
    else if (ls_req_ready) last_grant <= GRANT_LS;
    else if (if_req_ready) last_grant <= GRANT_IF;
  end

  assign pick_ls = ls_req_valid & (~if_elig | (last_grant == GRANT_IF));
`else
  assign pick_ls = ls_req_valid;
`endif
  assign pick_if = if_elig & ~pick_ls;

  // IF fetches carry no store data
  assign ld_wen   = pick_ls ? ls_req_wen   : 1'b0;
  assign ld_addr  = pick_ls ? ls_req_addr  : if_req_addr;
  assign ld_wdata = pick_ls ? ls_req_wdata : '0;
  assign ld_wmask = pick_ls ? ls_req_wmask : '0;

  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MASK_W (MASK_W)
  ) u_req_latch (
    .clk      (clk),
    .rst      (rst),
    .load     (if_req_ready | ls_req_ready),
    .wen_in   (ld_wen),
    .addr_in  (ld_addr),
    .wdata_in (ld_wdata),
    .wmask_in (ld_wmask),
    .wen      (mem.mem_req_wen),
    .addr     (mem.mem_req_addr),
    .wdata    (mem.mem_req_wdata),
    .wmask    (mem.mem_req_wmask)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (pick_ls)      state_nxt = ARB_REQ_LS;
        else if (pick_if) state_nxt = ARB_REQ_IF;
      end
      ARB_REQ_IF:  if (mem.mem_req_ready) state_nxt = ARB_WAIT_IF;
      ARB_WAIT_IF: if (mem.mem_rsp_valid) state_nxt = ARB_IDLE;
      ARB_REQ_LS:  if (mem.mem_req_ready) state_nxt = ARB_WAIT_LS;
      ARB_WAIT_LS: if (mem.mem_rsp_valid) state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // FSM outputs: grants in IDLE, bus request in REQ_x, response in WAIT_x
  always_comb begin
    if_req_ready      = 1'b0;
    ls_req_ready      = 1'b0;
    if_rsp_valid      = 1'b0;
    ls_rsp_valid      = 1'b0;
    mem.mem_req_valid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if_req_ready = run & pick_if;
        ls_req_ready = run & pick_ls;
      end
      ARB_REQ_IF, ARB_REQ_LS: mem.mem_req_valid = 1'b1;
      // A flush on the response cycle makes that fetch stale as well
      ARB_WAIT_IF: if_rsp_valid = mem.mem_rsp_valid & ~drop & ~flush;
      ARB_WAIT_LS: ls_rsp_valid = mem.mem_rsp_valid;
      default: ;
    endcase
  end

  // Stale-fetch flag: set by a flush while IF owns the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop <= 1'b0;
    else if (state == ARB_IDLE)
      drop <= 1'b0;
    else if (flush && (state == ARB_REQ_IF || state == ARB_WAIT_IF))
      drop <= 1'b1;
  end

  assign if_rsp_data  = if_rsp_valid ? mem.mem_rsp_data : '0;
  assign ls_rsp_data  = (ls_rsp_valid && !mem.mem_req_wen) ? mem.mem_rsp_data : '0;
  assign if_stall_req = run & if_req_valid & ~if_rsp_valid;
  assign ls_stall_req = run & ls_req_valid & ~ls_rsp_valid;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IF) and load/store (LS).
- One outstanding transaction at a time, sequenced by an FSM.
- Raises per-stage stall requests toward the hazard controller.
- Discards IF responses made stale by a branch/jump flush.
- Sits between the IF/LS stages and the external memory/AXI bridge.

Parameters:
- ADDR_W, 32, width of request address.
- DATA_W, 64, width of read/write data.
- MASK_W, DATA_W/8, byte write-mask width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF wants a fetch
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  fetch data valid (one-cycle pulse)
- if_rsp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  LS wants an access
- ls_req_wen  in  1  1 = store, 0 = load
- ls_req_addr  in  ADDR_W  access address
- ls_req_wdata  in  DATA_W  store data
- ls_req_wmask  in  MASK_W  store byte mask
- ls_req_ready  out  1  LS request accepted this cycle
- ls_rsp_valid  out  1  load data / store ack (one-cycle pulse)
- ls_rsp_data  out  DATA_W  load data (0 for stores)
- flush  in  1  IF redirect (ex/id jump); kills the pending IF transaction
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  write enable
- mem_req_addr  out  ADDR_W  address
- mem_req_wdata  out  DATA_W  write data
- mem_req_wmask  out  MASK_W  write mask
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DATA_W  response data
- if_stall_req  out  1  IF stage must stall
- ls_stall_req  out  1  LS stage must stall

Behaviour:
- FSM states: IDLE, REQ_IF, WAIT_IF, REQ_LS, WAIT_LS.
- Reset (rst=0, async):
  - state=IDLE; latched addr/wdata/wmask/wen=0; drop flag=0; last_grant=IF.
  - All outputs 0.
- IDLE:
  - If ls_req_valid: ls_req_ready=1, latch LS fields, go to REQ_LS.
  - Else if if_req_valid and !flush: if_req_ready=1, latch addr with wen=0, go to REQ_IF.
  - Fixed priority: LS over IF, because LS carries the older instruction.
- REQ_x:
  - mem_req_valid=1; mem_req_* driven from latched registers and held stable until mem_req_ready.
  - On mem_req_ready go to WAIT_x.
- WAIT_x:
  - On mem_rsp_valid: x_rsp_valid=1 combinationally that cycle, x_rsp_data=mem_rsp_data, go to IDLE.
  - For stores, ls_rsp_valid is the ack and ls_rsp_data=0.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1; with ready=1 and a 1-cycle memory, rsp at cycle 2; next request can be accepted at cycle 3.
- Flush:
  - flush in REQ_IF or WAIT_IF sets the drop flag. The transaction still completes on the bus, but if_rsp_valid is suppressed.
  - Drop flag clears on return to IDLE.
  - flush in IDLE blocks IF grant that cycle.
  - flush has no effect on LS.
- Stall requests (combinational):
  - if_stall_req = if_req_valid & !if_rsp_valid.
  - ls_stall_req = ls_req_valid & !ls_rsp_valid.
- mem_rsp_valid in IDLE/REQ_x is ignored; this covers stale responses after a mid-operation reset.
- Reset mid-transaction aborts to IDLE immediately; mem_req_valid drops asynchronously.
- No combinational path from mem_req_ready to any *_req_ready.

Optional Feature:
- ARB_ROUND_ROBIN_EN:
  - Defined: in IDLE with both requests valid, grant the requester not in last_grant; last_grant updates on every grant.
  - Undefined: fixed LS priority as above, and the last_grant register is not instantiated.

Decomposition:
- Shared package/define file:
  - FSM state encoding (3-bit localparams ARB_IDLE..ARB_WAIT_LS).
  - Requester IDs (GRANT_IF=0, GRANT_LS=1).
  - Reset-level constant reused from the core defines.
- One natural sub-module: arb_req_latch, the request register slice (addr/wdata/wmask/wen capture and hold).
- FSM and muxing stay in the top.

Test Plan:
- Single fetch: if_req_valid=1, addr=0x8000_0000, mem ready=1, rsp one cycle later with data=0x0000_0013 → if_req_ready at c0, mem_req_valid at c1, if_rsp_valid with data 0x13 at c2, if_stall_req high c0–c1.
- Contention: both valid in IDLE, LS store addr=0x8000_1000 wdata=0xDEAD_BEEF mask=0x0F → LS granted first, mem_req_wen=1 and mask=0x0F on bus; IF granted only after ls_rsp_valid.
- Backpressure: mem_req_ready held 0 for 4 cycles → mem_req_valid and addr/wdata remain stable for all 4 cycles, then accept.
- Flush during WAIT_IF: mem_rsp_valid arrives with 0xABCD → if_rsp_valid stays 0, FSM returns to IDLE, next IF request (new PC 0x8000_0040) granted.
- Async reset in WAIT_LS, then stray mem_rsp_valid after release → all outputs 0 during reset, stray response ignored, ls_rsp_valid never asserts.
- With ARB_ROUND_ROBIN_EN, both requesters continuously valid → grants alternate LS, IF, LS, IF.
